piso_serializer: RTL and testbench

//   Parallel-in/serial-out stage feeding the 1101 sequence detector's din input.

---
 rtl/piso_serializer.sv | 89 ++++++++
 tb/tb_piso_serializer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: accepts WIDTH-bit words over valid/ready and
// emits one bit per clock, streaming back-to-back words with no gap cycles.
module piso_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter logic        IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             last_bit,
  output logic             busy
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             accept;
  logic             at_last;

  assign at_last = (state_q == SHIFT) && (cnt_q == LAST_CNT);
  assign accept  = in_valid & in_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every next-state signal gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (accept) begin
      // A reload on the last-bit cycle is what keeps consecutive words gapless.
      state_d = SHIFT;
      shreg_d = in_data;
      cnt_d   = '0;
    end else if (state_q == SHIFT) begin
      if (at_last) begin
        state_d = IDLE;
      end else begin
        shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                            : {1'b0, shreg_q[WIDTH-1:1]};
        cnt_d   = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    in_ready   = 1'b0;
    dout       = IDLE_BIT;
    dout_valid = 1'b0;
    last_bit   = 1'b0;
    busy       = 1'b0;
    if (!rst) begin
      in_ready = (state_q == IDLE) || at_last;
    end
    if (state_q == SHIFT) begin
      dout       = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
      dout_valid = 1'b1;
      busy       = 1'b1;
      last_bit   = at_last;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: one MSB-first and one LSB-first instance,
// expected bit streams taken from hand-written words.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data, in_data_b;
  logic       in_valid, in_valid_b;
  logic       in_ready, dout, dout_valid, last_bit, busy;
  logic       in_ready_b, dout_b, dout_valid_b, last_bit_b, busy_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .dout(dout), .dout_valid(dout_valid),
    .last_bit(last_bit), .busy(busy)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .in_data(in_data_b), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .dout(dout_b), .dout_valid(dout_valid_b),
    .last_bit(last_bit_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".dout"},       dout,       1'b0);
    check({tag, ".dout_valid"}, dout_valid, 1'b0);
    check({tag, ".busy"},       busy,       1'b0);
    check({tag, ".last_bit"},   last_bit,   1'b0);
    check({tag, ".in_ready"},   in_ready,   1'b1);
  endtask

  // Expects the cycle after the accept edge; walks all 8 bits MSB first.
  task automatic expect_word_msb(input string tag, input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s.bit%0d", tag, i), dout, w[7-i]);
      check($sformatf("%s.vld%0d", tag, i), dout_valid, 1'b1);
      check($sformatf("%s.last%0d", tag, i), last_bit, (i == 7));
      check($sformatf("%s.rdy%0d", tag, i), in_ready, (i == 7));
      step();
    end
  endtask

  initial begin
    logic [7:0] w;
    logic [3:0] hist;
    int         hits, hit_at;

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    in_valid_b = 1'b0; in_data_b = 8'h00;

    // 1. reset, then hold idle for 5 cycles
    step();
    check("rst.in_ready_forced", in_ready, 1'b0);
    check("rst.dout_valid", dout_valid, 1'b0);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      check_idle($sformatf("idle%0d", i));
      check("idle.b_ready", in_ready_b, 1'b1);
      step();
    end

    // 2. single word 8'hD0 and a 1101 detector model on the stream
    in_data = 8'hD0; in_valid = 1'b1;
    step();
    in_valid = 1'b0; in_data = 8'h00;
    w = 8'hD0; hist = 4'h0; hits = 0; hit_at = -1;
    for (int i = 0; i < 8; i++) begin
      hist = {hist[2:0], dout};
      if (hist == 4'b1101) begin
        hits++;
        hit_at = i;
      end
      check($sformatf("d0.bit%0d", i), dout, w[7-i]);
      check($sformatf("d0.last%0d", i), last_bit, (i == 7));
      check($sformatf("d0.rdy%0d", i), in_ready, (i == 7));
      check($sformatf("d0.busy%0d", i), busy, 1'b1);
      step();
    end
    check("d0.det_hits", hits, 1);
    check("d0.det_pos", hit_at, 3);
    check_idle("d0.after");

    // 3. in_valid held high: A5 then 3C with no gap
    in_data = 8'hA5; in_valid = 1'b1;
    step();
    in_data = 8'h3C;
    for (int i = 0; i < 16; i++) begin
      w = (i < 8) ? 8'hA5 : 8'h3C;
      if (i == 8) in_valid = 1'b0;
      #1;
      check($sformatf("strm.bit%0d", i), dout, w[7-(i%8)]);
      check($sformatf("strm.vld%0d", i), dout_valid, 1'b1);
      check($sformatf("strm.last%0d", i), last_bit, ((i % 8) == 7));
      check($sformatf("strm.rdy%0d", i), in_ready, ((i % 8) == 7));
      step();
    end
    check_idle("strm.after");

    // 4. LSB-first instance, 8'h0B -> 1,1,0,1,0,0,0,0
    in_data_b = 8'h0B; in_valid_b = 1'b1;
    step();
    in_valid_b = 1'b0;
    w = 8'b0000_1011;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("lsb.bit%0d", i), dout_b, w[i]);
      check($sformatf("lsb.last%0d", i), last_bit_b, (i == 7));
      step();
    end
    check("lsb.after_vld", dout_valid_b, 1'b0);
    check("lsb.after_dout", dout_b, 1'b0);

    // 5. reset after the 3rd bit of 8'hFF, then 8'h81 in full
    in_data = 8'hFF; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("ff.bit%0d", i), dout, 1'b1);
      if (i < 2) step();
    end
    rst = 1'b1;
    step();
    check("ff.rst_dout", dout, 1'b0);
    check("ff.rst_vld", dout_valid, 1'b0);
    check("ff.rst_rdy", in_ready, 1'b0);
    rst = 1'b0;
    #1;
    check_idle("ff.post_rst");
    step();
    check_idle("ff.no_resume");
    in_data = 8'h81; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    expect_word_msb("w81", 8'h81);
    check_idle("w81.after");

    // 6. reset and in_valid together: nothing taken
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hAA;
    #1;
    check("rv.in_ready", in_ready, 1'b0);
    step();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check_idle("rv.after1");
    step();
    check_idle("rv.after2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
